// File: rtl/phase_frame_scheduler.sv
// Double-buffered phase bank: host writes fill a shadow bank, a commit arms a swap,
// and the active bank is replaced in one edge on the last count of a PWM period.
module phase_frame_scheduler #(
    parameter int NUM_CHANNELS = 256,
    parameter int CH_W         = 8,
    parameter int CLK_CNT_W    = 8,
    parameter int CLK_CNT_MAX  = 200
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CLK_CNT_W-1:0]              cnt,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [CH_W-1:0]                   wr_channel,
    input  logic [CLK_CNT_W-1:0]              wr_phase,
    input  logic                              wr_last,
    input  logic                              abort,
    output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases,
    output logic                              frame_swap,
    output logic                              commit_pending,
    output logic [15:0]                       frame_cnt,
    output logic                              chan_err,
    output logic                              phase_err
);

    localparam logic [CLK_CNT_W-1:0] LAST_CNT = CLK_CNT_W'(CLK_CNT_MAX - 1);

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 w_accept;
    logic                 w_at_last;
    logic                 w_swap;
    logic                 w_chan_ok;
    logic                 w_phase_ovf;
    logic [CLK_CNT_W-1:0] w_phase_clamped;
    logic [15:0]          w_frame_cnt_next;

    logic [CLK_CNT_W-1:0] r_shadow [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0] r_active [NUM_CHANNELS];
    logic                 r_frame_swap;
    logic [15:0]          r_frame_cnt;
    logic                 r_chan_err;
    logic                 r_phase_err;

    assign w_at_last        = (cnt == LAST_CNT);
    assign w_accept         = wr_valid && (r_state == S_IDLE);
    assign w_chan_ok        = 32'(wr_channel) < NUM_CHANNELS;
    assign w_phase_ovf      = 32'(wr_phase) >= CLK_CNT_MAX;
    assign w_phase_clamped  = w_phase_ovf ? LAST_CNT : wr_phase;
    assign w_frame_cnt_next = r_frame_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A period-end swap takes priority over a simultaneous abort.
    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && wr_last) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_at_last) begin
                    w_swap       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (abort) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_accept && (32'(wr_channel) == i)) begin
                    r_shadow[i] <= w_phase_clamped;
                end
                if (w_swap) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_swap <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_chan_err   <= 1'b0;
            r_phase_err  <= 1'b0;
        end else begin
            r_frame_swap <= w_swap;
            if (w_swap) begin
                r_frame_cnt <= w_frame_cnt_next;
            end
            if (w_accept && !w_chan_ok) begin
                r_chan_err <= 1'b1;
            end
            if (w_accept && w_chan_ok && w_phase_ovf) begin
                r_phase_err <= 1'b1;
            end
        end
    end

    assign wr_ready       = (r_state == S_IDLE);
    assign commit_pending = (r_state == S_ARMED);
    assign frame_swap     = r_frame_swap;
    assign frame_cnt      = r_frame_cnt;
    assign chan_err       = r_chan_err;
    assign phase_err      = r_phase_err;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_phase_out
        assign phases[g*CLK_CNT_W +: CLK_CNT_W] = r_active[g];
    end

endmodule

// File: tb/tb_phase_frame_scheduler.sv
// Directed bench for phase_frame_scheduler: write table, commit timing, abort,
// clamping/error flags, async reset and frame counter wrap.
module tb_phase_frame_scheduler;

    localparam int NUM_CHANNELS = 256;
    localparam int CH_W         = 9;
    localparam int CLK_CNT_W    = 8;
    localparam int CLK_CNT_MAX  = 200;
    localparam int WAIT_MAX     = 450;

    logic                              clk = 1'b0;
    logic                              rst = 1'b0;
    logic [CLK_CNT_W-1:0]              cnt = '0;
    logic                              wr_valid = 1'b0;
    logic                              wr_ready;
    logic [CH_W-1:0]                   wr_channel = '0;
    logic [CLK_CNT_W-1:0]              wr_phase = '0;
    logic                              wr_last = 1'b0;
    logic                              abort = 1'b0;
    logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases;
    logic                              frame_swap;
    logic                              commit_pending;
    logic [15:0]                       frame_cnt;
    logic                              chan_err;
    logic                              phase_err;

    int checks = 0;
    int errors = 0;
    int expFrames = 0;

    typedef struct {
        int ch;
        int ph;
        int expStored;
        bit inRange;
        bit expChanErr;
        bit expPhaseErr;
    } vec_t;

    vec_t vecs[6];

    phase_frame_scheduler #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CH_W        (CH_W),
        .CLK_CNT_W   (CLK_CNT_W),
        .CLK_CNT_MAX (CLK_CNT_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cnt           (cnt),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_channel    (wr_channel),
        .wr_phase      (wr_phase),
        .wr_last       (wr_last),
        .abort         (abort),
        .phases        (phases),
        .frame_swap    (frame_swap),
        .commit_pending(commit_pending),
        .frame_cnt     (frame_cnt),
        .chan_err      (chan_err),
        .phase_err     (phase_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] getPhase(int ch);
        return phases[ch*CLK_CNT_W +: CLK_CNT_W];
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: edge, settle, then advance the wrapping period counter.
    task automatic step();
        @(posedge clk);
        #1;
        cnt = (cnt == 8'(CLK_CNT_MAX - 1)) ? 8'd0 : cnt + 8'd1;
    endtask

    task automatic applyStimulus(int ch, int ph, bit last);
        wr_valid   = 1'b1;
        wr_channel = 9'(ch);
        wr_phase   = 8'(ph);
        wr_last    = last;
        step();
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
    endtask

    task automatic runToCnt(int target);
        for (int k = 0; k < WAIT_MAX && int'(cnt) != target; k++) step();
    endtask

    task automatic waitSwap(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < WAIT_MAX) begin
            step();
            n++;
            if (frame_swap) seen = 1'b1;
        end
        if (!seen) checkOutput("swap_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int swaps;
        int swapCnt;
        int readyBad;
        int c;

        vecs[0] = '{ch: 3,   ph: 250, expStored: 199, inRange: 1, expChanErr: 0, expPhaseErr: 1};
        vecs[1] = '{ch: 300, ph: 77,  expStored: 0,   inRange: 0, expChanErr: 1, expPhaseErr: 1};
        vecs[2] = '{ch: 5,   ph: 199, expStored: 199, inRange: 1, expChanErr: 1, expPhaseErr: 1};
        vecs[3] = '{ch: 7,   ph: 200, expStored: 199, inRange: 1, expChanErr: 1, expPhaseErr: 1};
        vecs[4] = '{ch: 8,   ph: 0,   expStored: 0,   inRange: 1, expChanErr: 1, expPhaseErr: 1};
        vecs[5] = '{ch: 255, ph: 42,  expStored: 42,  inRange: 1, expChanErr: 1, expPhaseErr: 1};

        #1 rst = 1'b1;
        #2;
        checkOutput("rst_phases_zero", 32'(phases == '0), 1);
        checkOutput("rst_wr_ready", wr_ready, 1);
        checkOutput("rst_frame_swap", frame_swap, 0);
        checkOutput("rst_commit_pending", commit_pending, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        checkOutput("rst_chan_err", chan_err, 0);
        checkOutput("rst_phase_err", phase_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = '0;

        // Basic commit: swap lands exactly on the cnt==199 edge.
        applyStimulus(0, 10, 0);
        applyStimulus(255, 150, 1);
        checkOutput("arm_commit_pending", commit_pending, 1);
        checkOutput("arm_wr_ready", wr_ready, 0);
        runToCnt(CLK_CNT_MAX - 1);
        checkOutput("preswap_ph0", getPhase(0), 0);
        checkOutput("preswap_ph255", getPhase(255), 0);
        checkOutput("preswap_frame_swap", frame_swap, 0);
        step();
        expFrames++;
        checkOutput("swap1_frame_swap", frame_swap, 1);
        checkOutput("swap1_ph0", getPhase(0), 10);
        checkOutput("swap1_ph255", getPhase(255), 150);
        checkOutput("swap1_frame_cnt", frame_cnt, 32'(expFrames));
        checkOutput("swap1_wr_ready", wr_ready, 1);
        step();
        checkOutput("swap1_pulse_end", frame_swap, 0);

        // Armed commit observed over 300 cycles: exactly one swap.
        applyStimulus(1, 20, 1);
        swaps = 0;
        swapCnt = -1;
        readyBad = 0;
        for (int i = 0; i < 300; i++) begin
            if (swaps == 0 && wr_ready !== 1'b0) readyBad++;
            c = int'(cnt);
            step();
            if (frame_swap) begin
                swaps++;
                swapCnt = c;
            end
        end
        expFrames++;
        checkOutput("hold_swap_count", swaps, 1);
        checkOutput("hold_swap_at_cnt", swapCnt, CLK_CNT_MAX - 1);
        checkOutput("hold_ready_low", readyBad, 0);
        checkOutput("hold_ph1", getPhase(1), 20);
        checkOutput("hold_frame_cnt", frame_cnt, 32'(expFrames));

        // Commit accepted on the last count waits one full period.
        runToCnt(CLK_CNT_MAX - 1);
        applyStimulus(2, 30, 1);
        waitSwap(n);
        expFrames++;
        checkOutput("late_commit_latency", n, CLK_CNT_MAX);
        checkOutput("late_commit_ph2", getPhase(2), 30);

        // Write table: clamping and out-of-range channels.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].ph, 0);
            checkOutput($sformatf("vec%0d_chan_err", i), chan_err, vecs[i].expChanErr);
            checkOutput($sformatf("vec%0d_phase_err", i), phase_err, vecs[i].expPhaseErr);
            checkOutput($sformatf("vec%0d_wr_ready", i), wr_ready, 1);
        end
        applyStimulus(9, 1, 1);
        waitSwap(n);
        expFrames++;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].inRange)
                checkOutput($sformatf("vec%0d_phase", i), getPhase(vecs[i].ch), 32'(vecs[i].expStored));
        end
        checkOutput("oob_no_alias_ph44", getPhase(44), 0);
        checkOutput("table_ph9", getPhase(9), 1);
        checkOutput("table_frame_cnt", frame_cnt, 32'(expFrames));

        // Abort mid-period cancels the swap but keeps the shadow data.
        applyStimulus(10, 100, 1);
        runToCnt(50);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_commit_pending", commit_pending, 0);
        checkOutput("abort_wr_ready", wr_ready, 1);
        swaps = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (frame_swap) swaps++;
        end
        checkOutput("abort_no_swap", swaps, 0);
        checkOutput("abort_frame_cnt", frame_cnt, 32'(expFrames));
        checkOutput("abort_ph10", getPhase(10), 0);

        // Abort on the last count loses to the swap.
        applyStimulus(11, 111, 1);
        runToCnt(CLK_CNT_MAX - 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expFrames++;
        checkOutput("abort_last_swap", frame_swap, 1);
        checkOutput("abort_last_ph10", getPhase(10), 100);
        checkOutput("abort_last_ph11", getPhase(11), 111);
        checkOutput("abort_last_frame_cnt", frame_cnt, 32'(expFrames));
        checkOutput("flags_sticky_chan", chan_err, 1);
        checkOutput("flags_sticky_phase", phase_err, 1);

        // Async reset while armed.
        step();
        applyStimulus(12, 5, 1);
        runToCnt(120);
        checkOutput("prerst_commit_pending", commit_pending, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_phases_zero", 32'(phases == '0), 1);
        checkOutput("midrst_commit_pending", commit_pending, 0);
        checkOutput("midrst_wr_ready", wr_ready, 1);
        checkOutput("midrst_frame_cnt", frame_cnt, 0);
        checkOutput("midrst_chan_err", chan_err, 0);
        checkOutput("midrst_phase_err", phase_err, 0);
        #1 rst = 1'b0;
        cnt = '0;
        expFrames = 0;
        swaps = 0;
        for (int i = 0; i < 210; i++) begin
            step();
            if (frame_swap) swaps++;
        end
        checkOutput("postrst_no_swap", swaps, 0);
        checkOutput("postrst_ph12", getPhase(12), 0);

        // Frame counter wrap: preload via the increment path, then swap once more.
        force dut.w_frame_cnt_next = 16'hFFFF;
        applyStimulus(13, 7, 1);
        waitSwap(n);
        release dut.w_frame_cnt_next;
        checkOutput("wrap_preload", frame_cnt, 16'hFFFF);
        step();
        applyStimulus(13, 8, 1);
        waitSwap(n);
        checkOutput("wrap_frame_cnt", frame_cnt, 0);
        checkOutput("wrap_ph13", getPhase(13), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_frame_scheduler.md
Name: phase_frame_scheduler

Overview:
- Double-buffered phase bank controller between the host phase-update path (receiver/phase parsing) and the per-channel pwm instances.
- Host writes land in a shadow bank; a commit arms a swap, and the active bank updates atomically on the last count of a PWM period, so all channels change phase on the same period boundary.
- Lives in the pwm_clk domain. The shared period counter comes in on cnt; the active bank drives the pwm phase inputs.

Parameters:
- NUM_CHANNELS, 256, number of transducer channels.
- CH_W, 8, channel index width; must satisfy 2**CH_W >= NUM_CHANNELS.
- CLK_CNT_W, 8, phase and counter width.
- CLK_CNT_MAX, 200, PWM period in clocks; cnt runs 0..CLK_CNT_MAX-1.

Ports:
- clk  in  1  pwm clock.
- rst  in  1  asynchronous active-high reset.
- cnt  in  CLK_CNT_W  shared PWM period counter.
- wr_valid  in  1  phase write request.
- wr_ready  out  1  write accept.
- wr_channel  in  CH_W  target channel.
- wr_phase  in  CLK_CNT_W  phase value.
- wr_last  in  1  commit the frame after this write.
- abort  in  1  cancel a pending commit.
- phases  out  CLK_CNT_W x NUM_CHANNELS  active phase bank, one entry per channel.
- frame_swap  out  1  one-cycle pulse, asserted in the same edge the active bank updates.
- commit_pending  out  1  high while ARMED.
- frame_cnt  out  16  completed swaps; wraps 65535 -> 0.
- chan_err  out  1  sticky: an out-of-range channel was written.
- phase_err  out  1  sticky: a phase was clamped.

Behaviour:
- Reset (async, active-high) sets:
  - shadow and active banks all 0;
  - state IDLE;
  - wr_ready=1; frame_swap=0; commit_pending=0; frame_cnt=0; chan_err=0; phase_err=0.
- A write is accepted when wr_valid && wr_ready. Shadow[wr_channel] updates at that edge, so latency is 1 cycle.
- Other channels keep their previous shadow value; a partial frame is legal.
- wr_phase >= CLK_CNT_MAX: store CLK_CNT_MAX-1 and set phase_err. phase_err clears only on rst.
- wr_channel >= NUM_CHANNELS: accept the write, discard the data, set chan_err. chan_err clears only on rst.
  - If that write carries wr_last, the commit still arms.
- FSM, IDLE:
  - wr_ready=1.
  - An accepted write with wr_last=1 transitions to ARMED.
  - abort is ignored in IDLE.
- FSM, ARMED:
  - wr_ready=0 and commit_pending=1; no shadow writes occur.
  - On the edge where cnt==CLK_CNT_MAX-1 is sampled: active<=shadow (all channels at once), frame_swap=1 for that cycle, frame_cnt+1, transition to IDLE.
  - Because ARMED is entered only after the acceptance edge, a wr_last accepted while cnt==CLK_CNT_MAX-1 swaps one full period later. The earliest swap is the next occurrence of CLK_CNT_MAX-1.
  - abort=1 with cnt!=CLK_CNT_MAX-1: transition to IDLE with no swap; the shadow bank is retained.
  - abort=1 with cnt==CLK_CNT_MAX-1 in the same cycle: the swap wins and the abort is ignored.
- Active bank changes only on swap edges; pwm inputs never see a mixed frame.
- cnt is assumed monotonic-wrapping. The block does not check it, and any value >= CLK_CNT_MAX never triggers a swap.
- Reset asserted mid-ARMED discards the pending commit and both banks.
- frame_swap is deasserted in every cycle except a swap cycle.

Test Plan:
- Reset, then write ch0=10 and ch255=150 with wr_last on the second write -> phases unchanged (0) until cnt==199; at that edge phases[0]=10, phases[255]=150, frame_swap pulses for 1 cycle, frame_cnt=1.
- Commit armed, then 300 cycles pass -> exactly one swap, at the first cnt==199; wr_ready=0 from the arming edge until the swap; no further swaps.
- wr_last accepted in the cycle cnt==199 -> no swap that period; swap occurs 200 cycles later.
- Write ch3=250 (CLK_CNT_MAX=200) -> shadow[3]=199 and phase_err=1. Write ch300 (CH_W=9) -> no bank change and chan_err=1. Both flags hold until rst.
- Armed commit with abort at cnt=50 -> back to IDLE, no frame_swap, frame_cnt unchanged. Arm again with abort at cnt==199 -> swap occurs.
- Assert rst while ARMED at cnt=120 -> phases all 0, commit_pending=0, wr_ready=1 immediately (async). Force frame_cnt to wrap: 65536 swaps -> frame_cnt=0.
